// File: rtl/regfile_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard_if
// Brief    : Observed port bundle of a dual-write/dual-read register file.
// Revision : 1.0
// ============================================================================
interface regfile_scoreboard_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] ReadRegister1;
  logic [ADDR_W-1:0] ReadRegister2;
  logic [DATA_W-1:0] ReadData1;
  logic [DATA_W-1:0] ReadData2;
  logic [ADDR_W-1:0] WriteRegister1;
  logic [ADDR_W-1:0] WriteRegister2;
  logic [DATA_W-1:0] WriteData1;
  logic [DATA_W-1:0] WriteData2;
  logic              RegWrite1;
  logic              RegWrite2;

  modport master (
    output ReadRegister1, ReadRegister2, ReadData1, ReadData2,
    output WriteRegister1, WriteRegister2, WriteData1, WriteData2,
    output RegWrite1, RegWrite2
  );

  modport slave (
    input ReadRegister1, ReadRegister2, ReadData1, ReadData2,
    input WriteRegister1, WriteRegister2, WriteData1, WriteData2,
    input RegWrite1, RegWrite2
  );
endinterface
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : regfile_scoreboard
// Brief    : Passive checker shadowing a dual-write/dual-read register file.
//            Macro REGFILE_SB_FWD_EN models a write-through register file.
// Revision : 1.0
// ============================================================================
module regfile_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Enable,
  input  logic                Clear,
  regfile_scoreboard_if.slave rf,
  output logic [1:0]          Fault,
  output logic [CNT_W-1:0]    FaultCount,
  output logic [CNT_W-1:0]    CheckCount,
  output logic                FirstFaultValid,
  output logic                FirstFaultPort,
  output logic [ADDR_W-1:0]   FirstFaultAddr,
  output logic [DATA_W-1:0]   FirstFaultExp,
  output logic [DATA_W-1:0]   FirstFaultAct
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] shadow_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;

  logic [1:0]        fault_q, fault_d;
  logic [CNT_W-1:0]  fcnt_q, fcnt_d;
  logic [CNT_W-1:0]  ccnt_q, ccnt_d;
  logic              ff_valid_q, ff_valid_d;
  logic              ff_port_q, ff_port_d;
  logic [ADDR_W-1:0] ff_addr_q, ff_addr_d;
  logic [DATA_W-1:0] ff_exp_q, ff_exp_d;
  logic [DATA_W-1:0] ff_act_q, ff_act_d;

  logic [ADDR_W-1:0] rd_addr [2];
  logic [DATA_W-1:0] rd_data [2];
  logic [DATA_W-1:0] exp_data [2];
  logic [1:0]        do_chk;
  logic [1:0]        mis;
  logic [1:0]        n_chk, n_mis;
  logic              active;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
    return s[CNT_W] ? '1 : s[CNT_W-1:0];
  endfunction

  assign active = Enable && !Clear;

  always_comb begin
    rd_addr[0] = rf.ReadRegister1;
    rd_addr[1] = rf.ReadRegister2;
    rd_data[0] = rf.ReadData1;
    rd_data[1] = rf.ReadData2;
    for (int p = 0; p < 2; p++) begin
      exp_data[p] = shadow_q[rd_addr[p]];
      do_chk[p]   = valid_q[rd_addr[p]];
`ifdef REGFILE_SB_FWD_EN
      // Write-through: same-cycle write data is what the read should see.
      if (rf.RegWrite2 && (rf.WriteRegister2 == rd_addr[p])) begin
        exp_data[p] = rf.WriteData2;
        do_chk[p]   = 1'b1;
      end else if (rf.RegWrite1 && (rf.WriteRegister1 == rd_addr[p])) begin
        exp_data[p] = rf.WriteData1;
        do_chk[p]   = 1'b1;
      end
`endif
      do_chk[p] = do_chk[p] && active;
      mis[p]    = do_chk[p] && (rd_data[p] != exp_data[p]);
    end
  end

  assign n_chk = {1'b0, do_chk[0]} + {1'b0, do_chk[1]};
  assign n_mis = {1'b0, mis[0]} + {1'b0, mis[1]};

  always_comb begin
    valid_d = valid_q;
    if (rf.RegWrite1) valid_d[rf.WriteRegister1] = 1'b1;
    if (rf.RegWrite2) valid_d[rf.WriteRegister2] = 1'b1;
  end

  always_comb begin
    fault_d    = mis;
    fcnt_d     = fcnt_q;
    ccnt_d     = ccnt_q;
    ff_valid_d = ff_valid_q;
    ff_port_d  = ff_port_q;
    ff_addr_d  = ff_addr_q;
    ff_exp_d   = ff_exp_q;
    ff_act_d   = ff_act_q;
    if (Clear) begin
      fault_d    = '0;
      fcnt_d     = '0;
      ccnt_d     = '0;
      ff_valid_d = 1'b0;
      ff_port_d  = 1'b0;
      ff_addr_d  = '0;
      ff_exp_d   = '0;
      ff_act_d   = '0;
    end else begin
      ccnt_d = sat_add(ccnt_q, n_chk);
      fcnt_d = sat_add(fcnt_q, n_mis);
      // Port 1 takes the capture when both ports fail together.
      if (!ff_valid_q && (mis != 2'b00)) begin
        ff_valid_d = 1'b1;
        ff_port_d  = !mis[0];
        ff_addr_d  = mis[0] ? rd_addr[0]  : rd_addr[1];
        ff_exp_d   = mis[0] ? exp_data[0] : exp_data[1];
        ff_act_d   = mis[0] ? rd_data[0]  : rd_data[1];
      end
    end
  end

  // Later assignment wins, giving port 2 priority on a write collision.
  always_ff @(posedge Clk) begin
    if (rf.RegWrite1) shadow_q[rf.WriteRegister1] <= rf.WriteData1;
    if (rf.RegWrite2) shadow_q[rf.WriteRegister2] <= rf.WriteData2;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      valid_q    <= '0;
      fault_q    <= '0;
      fcnt_q     <= '0;
      ccnt_q     <= '0;
      ff_valid_q <= 1'b0;
      ff_port_q  <= 1'b0;
      ff_addr_q  <= '0;
      ff_exp_q   <= '0;
      ff_act_q   <= '0;
    end else begin
      valid_q    <= valid_d;
      fault_q    <= fault_d;
      fcnt_q     <= fcnt_d;
      ccnt_q     <= ccnt_d;
      ff_valid_q <= ff_valid_d;
      ff_port_q  <= ff_port_d;
      ff_addr_q  <= ff_addr_d;
      ff_exp_q   <= ff_exp_d;
      ff_act_q   <= ff_act_d;
    end
  end

  assign Fault           = fault_q;
  assign FaultCount      = fcnt_q;
  assign CheckCount      = ccnt_q;
  assign FirstFaultValid = ff_valid_q;
  assign FirstFaultPort  = ff_port_q;
  assign FirstFaultAddr  = ff_addr_q;
  assign FirstFaultExp   = ff_exp_q;
  assign FirstFaultAct   = ff_act_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_scoreboard.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_scoreboard
// Brief    : Scoreboard bench for regfile_scoreboard (default and 4-bit counters).
// Revision : 1.0
// ============================================================================
module tb_regfile_scoreboard;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 16;
  localparam int SAT_W  = 4;
  localparam int MAXC   = (1 << CNT_W) - 1;
  localparam int MAXS   = (1 << SAT_W) - 1;

  logic Clk, Reset, Enable, Clear;

  regfile_scoreboard_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) rf_if ();

  logic [1:0]        fault, s_fault;
  logic [CNT_W-1:0]  fcnt, ccnt;
  logic [SAT_W-1:0]  s_fcnt, s_ccnt;
  logic              ffv, ffp, s_ffv, s_ffp;
  logic [ADDR_W-1:0] ffa, s_ffa;
  logic [DATA_W-1:0] ffe, ffact, s_ffe, s_ffact;

  regfile_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) u_dut (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .Clear(Clear), .rf(rf_if),
    .Fault(fault), .FaultCount(fcnt), .CheckCount(ccnt),
    .FirstFaultValid(ffv), .FirstFaultPort(ffp), .FirstFaultAddr(ffa),
    .FirstFaultExp(ffe), .FirstFaultAct(ffact)
  );

  regfile_scoreboard #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(SAT_W)) u_dut_sat (
    .Clk(Clk), .Reset(Reset), .Enable(Enable), .Clear(Clear), .rf(rf_if),
    .Fault(s_fault), .FaultCount(s_fcnt), .CheckCount(s_ccnt),
    .FirstFaultValid(s_ffv), .FirstFaultPort(s_ffp), .FirstFaultAddr(s_ffa),
    .FirstFaultExp(s_ffe), .FirstFaultAct(s_ffact)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct {
    logic [1:0]  fault;
    int          fc;
    int          cc;
    int          fc4;
    int          cc4;
    logic        ffv;
    logic        ffp;
    logic [4:0]  ffa;
    logic [31:0] ffe;
    logic [31:0] ffact;
  } exp_t;

  exp_t exp_q[$];

  logic [31:0] m_sh  [32];
  logic        m_val [32];
  int          m_fc, m_cc, m_fc4, m_cc4;
  logic        m_ffv, m_ffp;
  logic [4:0]  m_ffa;
  logic [31:0] m_ffe, m_ffact;

  int n_asserts = 0;
  int n_fail    = 0;

  task automatic check_value(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    n_asserts++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_sh[i]  = 32'h0;
      m_val[i] = 1'b0;
    end
    m_fc = 0; m_cc = 0; m_fc4 = 0; m_cc4 = 0;
    m_ffv = 1'b0; m_ffp = 1'b0; m_ffa = '0; m_ffe = '0; m_ffact = '0;
  endtask

  task automatic check_zero(input string tag);
    check_value({tag, "_fault"},     fault,   0);
    check_value({tag, "_fcnt"},      fcnt,    0);
    check_value({tag, "_ccnt"},      ccnt,    0);
    check_value({tag, "_ffv"},       ffv,     0);
    check_value({tag, "_ffp"},       ffp,     0);
    check_value({tag, "_ffa"},       ffa,     0);
    check_value({tag, "_ffe"},       ffe,     0);
    check_value({tag, "_ffact"},     ffact,   0);
    check_value({tag, "_sat_fault"}, s_fault, 0);
    check_value({tag, "_sat_fcnt"},  s_fcnt,  0);
    check_value({tag, "_sat_ccnt"},  s_ccnt,  0);
    check_value({tag, "_sat_ffv"},   s_ffv,   0);
  endtask

  task automatic cyc(input logic [4:0] rr1, input logic [31:0] rd1,
                     input logic [4:0] rr2, input logic [31:0] rd2,
                     input logic we1, input logic [4:0] wr1, input logic [31:0] wd1,
                     input logic we2, input logic [4:0] wr2, input logic [31:0] wd2,
                     input logic en, input logic clr);
    logic [4:0]  rr  [2];
    logic [31:0] rd  [2];
    logic [31:0] ex  [2];
    logic        chk [2];
    logic [1:0]  mis;
    int          nchk, nmis;
    exp_t        e;

    rf_if.ReadRegister1 = rr1;  rf_if.ReadData1 = rd1;
    rf_if.ReadRegister2 = rr2;  rf_if.ReadData2 = rd2;
    rf_if.RegWrite1 = we1; rf_if.WriteRegister1 = wr1; rf_if.WriteData1 = wd1;
    rf_if.RegWrite2 = we2; rf_if.WriteRegister2 = wr2; rf_if.WriteData2 = wd2;
    Enable = en;
    Clear  = clr;

    rr[0] = rr1; rr[1] = rr2; rd[0] = rd1; rd[1] = rd2;
    nchk = 0; nmis = 0; mis = 2'b00;
    for (int p = 0; p < 2; p++) begin
      ex[p]  = m_sh[rr[p]];
      chk[p] = m_val[rr[p]];
`ifdef REGFILE_SB_FWD_EN
      if (we2 && wr2 == rr[p]) begin
        ex[p] = wd2; chk[p] = 1'b1;
      end else if (we1 && wr1 == rr[p]) begin
        ex[p] = wd1; chk[p] = 1'b1;
      end
`endif
      if (en && !clr && chk[p]) begin
        nchk++;
        if (rd[p] != ex[p]) begin
          nmis++;
          mis[p] = 1'b1;
        end
      end
    end

    if (clr) begin
      m_fc = 0; m_cc = 0; m_fc4 = 0; m_cc4 = 0;
      m_ffv = 1'b0; m_ffp = 1'b0; m_ffa = '0; m_ffe = '0; m_ffact = '0;
      e.fault = 2'b00;
    end else begin
      e.fault = mis;
      m_cc  = (m_cc  + nchk > MAXC) ? MAXC : m_cc  + nchk;
      m_fc  = (m_fc  + nmis > MAXC) ? MAXC : m_fc  + nmis;
      m_cc4 = (m_cc4 + nchk > MAXS) ? MAXS : m_cc4 + nchk;
      m_fc4 = (m_fc4 + nmis > MAXS) ? MAXS : m_fc4 + nmis;
      if (!m_ffv && mis != 2'b00) begin
        m_ffv = 1'b1;
        if (mis[0]) begin
          m_ffp = 1'b0; m_ffa = rr[0]; m_ffe = ex[0]; m_ffact = rd[0];
        end else begin
          m_ffp = 1'b1; m_ffa = rr[1]; m_ffe = ex[1]; m_ffact = rd[1];
        end
      end
    end

    if (we1) begin m_sh[wr1] = wd1; m_val[wr1] = 1'b1; end
    if (we2) begin m_sh[wr2] = wd2; m_val[wr2] = 1'b1; end

    e.fc = m_fc; e.cc = m_cc; e.fc4 = m_fc4; e.cc4 = m_cc4;
    e.ffv = m_ffv; e.ffp = m_ffp; e.ffa = m_ffa; e.ffe = m_ffe; e.ffact = m_ffact;
    exp_q.push_back(e);

    @(posedge Clk);
    #1;
    if (exp_q.size() == 0) begin
      check_value("sb_underflow", 0, 1);
    end else begin
      e = exp_q.pop_front();
      check_value("fault",       fault,   e.fault);
      check_value("fault_count", fcnt,    64'(e.fc));
      check_value("check_count", ccnt,    64'(e.cc));
      check_value("ff_valid",    ffv,     e.ffv);
      check_value("ff_port",     ffp,     e.ffp);
      check_value("ff_addr",     ffa,     e.ffa);
      check_value("ff_exp",      ffe,     e.ffe);
      check_value("ff_act",      ffact,   e.ffact);
      check_value("sat_fault",   s_fault, e.fault);
      check_value("sat_fcount",  s_fcnt,  64'(e.fc4));
      check_value("sat_ccount",  s_ccnt,  64'(e.cc4));
    end
  endtask

  logic [4:0]  a1, a2, w1, w2;
  logic [31:0] d1, d2;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached before end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Reset = 1'b1; Enable = 1'b1; Clear = 1'b0;
    rf_if.ReadRegister1 = '0; rf_if.ReadRegister2 = '0;
    rf_if.ReadData1 = '0; rf_if.ReadData2 = '0;
    rf_if.WriteRegister1 = '0; rf_if.WriteRegister2 = '0;
    rf_if.WriteData1 = '0; rf_if.WriteData2 = '0;
    rf_if.RegWrite1 = 1'b0; rf_if.RegWrite2 = 1'b0;
    model_reset();
    #2;
    check_zero("reset");
    @(posedge Clk); #1;
    Reset = 1'b0;

    // reg0/reg1 written, then read back correctly
    cyc(5'd2, 32'h0, 5'd3, 32'h0, 1, 5'd0, 32'h0000_1234, 1, 5'd1, 32'h0000_ABCD, 1, 0);
    cyc(5'd0, 32'h0000_1234, 5'd1, 32'h0000_ABCD, 0, 0, 0, 0, 0, 0, 1, 0);
    // write collision on reg1: port 2 value must win
    cyc(5'd0, 32'h0000_1234, 5'd0, 32'h0000_1234, 1, 5'd1, 32'h11, 1, 5'd1, 32'h22, 1, 0);
    cyc(5'd0, 32'h0000_1234, 5'd1, 32'h11, 0, 0, 0, 0, 0, 0, 1, 0);
    // unwritten registers are not checked
    cyc(5'd10, 32'hDEAD_0000, 5'd4, 32'hBEEF_0000, 0, 0, 0, 0, 0, 0, 1, 0);
    // clear, then a double mismatch captures port 1; a later one leaves it
    cyc(5'd0, 32'h0, 5'd1, 32'h0, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc(5'd0, 32'hBAD0, 5'd1, 32'hBAD1, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(5'd0, 32'h0000_1234, 5'd1, 32'h99, 0, 0, 0, 0, 0, 0, 1, 0);
    // 20 mismatches saturate the 4-bit counters
    for (int i = 0; i < 10; i++)
      cyc(5'd0, 32'hF00 + i, 5'd1, 32'hE00 + i, 0, 0, 0, 0, 0, 0, 1, 0);
    cyc(5'd0, 32'h0, 5'd1, 32'h0, 0, 0, 0, 0, 0, 0, 1, 1);
    cyc(5'd0, 32'h0000_1234, 5'd1, 32'h22, 0, 0, 0, 0, 0, 0, 1, 0);
    // disabled: no fault or count, shadow still tracks the write to reg2
    cyc(5'd0, 32'hBAD, 5'd1, 32'hBAD, 1, 5'd2, 32'h77, 0, 0, 0, 0, 0);
    cyc(5'd2, 32'h77, 5'd1, 32'h22, 0, 0, 0, 0, 0, 0, 1, 0);
    // same-cycle read/write of reg0
    cyc(5'd2, 32'h77, 5'd1, 32'h22, 1, 5'd0, 32'h5, 0, 0, 0, 1, 0);
    cyc(5'd0, 32'h9, 5'd2, 32'h77, 1, 5'd0, 32'h9, 0, 0, 0, 1, 0);

    // asynchronous reset between clock edges
    #2 Reset = 1'b1;
    #1 check_zero("midrun_reset");
    model_reset();
    @(posedge Clk); #1;
    Reset = 1'b0;
    cyc(5'd0, 32'h1234, 5'd1, 32'h0, 0, 0, 0, 0, 0, 0, 1, 0);

    for (int i = 0; i < 40; i++) begin
      a1 = 5'($urandom_range(0, 7));
      a2 = 5'($urandom_range(0, 7));
      w1 = 5'($urandom_range(0, 7));
      w2 = 5'($urandom_range(0, 7));
      d1 = ($urandom_range(0, 3) != 0) ? m_sh[a1] : $urandom();
      d2 = ($urandom_range(0, 3) != 0) ? m_sh[a2] : $urandom();
      cyc(a1, d1, a2, d2,
          1'($urandom_range(0, 1)), w1, $urandom(),
          1'($urandom_range(0, 1)), w2, $urandom(),
          ($urandom_range(0, 7) != 0), ($urandom_range(0, 15) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Passive self-checking monitor for the dual-write/dual-read RegisterFile.
- Observes every port of the register file and holds a 32-entry shadow copy built from the write ports.
- Compares both read ports against the shadow on every rising Clk edge.
- Reports per-cycle faults, a saturating fault counter and a first-fault capture, so register file benches become self-checking instead of waveform-inspected.

Parameters:
- DATA_W, 32, width of register data.
- ADDR_W, 5, register address width; depth = 2**ADDR_W.
- CNT_W, 16, width of FaultCount and CheckCount.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Reset  input  1  asynchronous, active-high reset.
- Enable  input  1  when low: no checks or counting; shadow still tracks writes.
- Clear  input  1  synchronous clear of counters, Fault and first-fault capture; shadow kept.
- ReadRegister1  input  ADDR_W  observed read address, port 1.
- ReadRegister2  input  ADDR_W  observed read address, port 2.
- ReadData1  input  DATA_W  observed read data, port 1.
- ReadData2  input  DATA_W  observed read data, port 2.
- WriteRegister1  input  ADDR_W  observed write address, port 1.
- WriteRegister2  input  ADDR_W  observed write address, port 2.
- WriteData1  input  DATA_W  observed write data, port 1.
- WriteData2  input  DATA_W  observed write data, port 2.
- RegWrite1  input  1  observed write enable, port 1.
- RegWrite2  input  1  observed write enable, port 2.
- Fault  output  2  registered per-port mismatch flags; bit0 = port 1, bit1 = port 2.
- FaultCount  output  CNT_W  total mismatches, saturating.
- CheckCount  output  CNT_W  total comparisons performed, saturating.
- FirstFaultValid  output  1  first-fault capture is loaded.
- FirstFaultPort  output  1  0 = port 1, 1 = port 2.
- FirstFaultAddr  output  ADDR_W  register address of first fault.
- FirstFaultExp  output  DATA_W  expected data at first fault.
- FirstFaultAct  output  DATA_W  observed data at first fault.

Behaviour:
- Reset (asynchronous):
  - All outputs go to 0.
  - All 32 shadow valid bits are cleared; shadow data is don't-care.
- Modelled register-file semantics (decided):
  - Writes commit on the rising Clk edge.
  - Reads are combinational from the pre-edge state.
  - All registers are writable, including register 0.
  - Same-address collision with both RegWrite1 and RegWrite2 high: port 2 wins.
- Shadow update at each edge:
  - Write port 1 first, then port 2.
  - Each write sets the valid bit of its address.
- Check at each edge, when Enable=1 and Clear=0, per read port p:
  - If the valid bit of ReadRegister_p is set, compare ReadData_p against the pre-edge shadow entry.
  - Unwritten registers are skipped: no check, no count, no fault.
- Fault:
  - Fault[p] is registered: high for exactly one cycle after the edge where port p mismatched.
  - Latency is 1 cycle.
- Counters:
  - CheckCount increments by the number of comparisons that edge (0, 1 or 2).
  - FaultCount increments by the number of mismatches (0, 1 or 2).
  - Both saturate at 2**CNT_W-1 and never wrap.
- First-fault capture:
  - Loaded on the first mismatch while FirstFaultValid=0.
  - If both ports fail on the same edge, port 1 is captured.
  - Held until Clear or Reset.
- Clear=1: counters, Fault and first-fault capture go to 0 at the edge; shadow update still occurs; no check that edge.
- Enable=0: shadow still updates; Fault is driven 0 next cycle; counters hold.
- Reset mid-run: all state is cleared immediately; checking restarts with an empty shadow.
- Read of an address being written in the same cycle: compared against the OLD value (non-forwarding), unless the optional feature below is compiled in.

Optional Feature:
- Macro: REGFILE_SB_FWD_EN.
- Defined: write-through register file is modelled.
  - Expected read value = the same-cycle write data when RegWrite targets ReadRegister, with port 2 priority on collision.
  - Such a read is checked even if the entry was previously unwritten.
- Undefined: expected value is always the pre-edge shadow entry, as described above.

Test Plan:
- Reset, write reg0=0x0000_1234 via port 1 and reg1=0x0000_ABCD via port 2, then read ports 0/1 next cycle with correct data -> Fault=0, CheckCount=2, FaultCount=0.
- Collision: RegWrite1=RegWrite2=1, both addr 1, data 0x11/0x22; next read of reg1 returning 0x11 -> Fault=2'b10, FaultCount=1, FirstFaultAddr=1, FirstFaultExp=0x22, FirstFaultAct=0x11.
- Read of never-written reg10 and reg4 with arbitrary data -> no check, CheckCount unchanged, Fault=0.
- Both ports mismatch on the same edge -> Fault=2'b11, FaultCount+=2, first-fault capture reports port 1; a later mismatch leaves the capture unchanged.
- Force FaultCount near max (CNT_W=4 build, 20 mismatches) -> FaultCount holds 15; then Clear -> all counters 0, FirstFaultValid=0, shadow retained (next correct read gives no fault).
- Same-cycle read/write of reg0 (old 0x5, new 0x9), DUT returns 0x9 -> fault without REGFILE_SB_FWD_EN, no fault with it; assert Reset mid-sequence -> outputs 0 immediately, without waiting for a Clk edge.
